// File: rtl/cache_controller.sv
//==============================================================================
// Module      : cache_controller
// Description : Read-path controller for a direct-mapped cache. It probes the
//               cache, fetches 4-word blocks from memory on a miss and returns
//               the requested word. The optional hit/miss counters are enabled
//               with `define CACHE_STATS_EN.
// Revision    : 1.0 - initial release
//==============================================================================
`default_nettype none

`ifndef WORD_LENGTH
`define WORD_LENGTH 32
`endif

module cache_controller #(
  parameter int ADDR_WIDTH = 15,
  parameter int WORD_WIDTH = `WORD_LENGTH
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  cpu_read,
  input  logic [ADDR_WIDTH-1:0] cpu_address,
  output logic                  cpu_ready,
  output logic [WORD_WIDTH-1:0] cpu_data,
  output logic                  cache_read,
  output logic                  cache_write,
  output logic [ADDR_WIDTH-1:0] cache_address,
  output logic [WORD_WIDTH-1:0] cache_data1,
  output logic [WORD_WIDTH-1:0] cache_data2,
  output logic [WORD_WIDTH-1:0] cache_data3,
  output logic [WORD_WIDTH-1:0] cache_data4,
  input  logic                  cache_hit,
  input  logic [WORD_WIDTH-1:0] cache_out,
  output logic                  mem_read,
  output logic [ADDR_WIDTH-1:0] mem_address,
  input  logic                  mem_valid,
  input  logic [WORD_WIDTH-1:0] mem_data
`ifdef CACHE_STATS_EN
  ,
  output logic [15:0]           hit_count,
  output logic [15:0]           miss_count
`endif
);

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    COMPARE = 3'd1,
    FETCH   = 3'd2,
    FILL    = 3'd3,
    READ    = 3'd4,
    DONE    = 3'd5
  } state_t;

  state_t                r_state;
  state_t                w_state_next;
  logic [ADDR_WIDTH-1:0] r_addr;
  logic [WORD_WIDTH-1:0] r_buf [0:3];
  logic [1:0]            r_beat;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state  <= IDLE;
      r_addr   <= '0;
      cpu_data <= '0;
      r_beat   <= 2'd0;
      for (int i = 0; i < 4; i++) r_buf[i] <= '0;
    end else begin
      r_state <= w_state_next;
      case (r_state)
        IDLE:    if (cpu_read) r_addr <= cpu_address;
        COMPARE: if (!cache_hit) r_beat <= 2'd0;
        FETCH: begin
          if (mem_valid) begin
            r_buf[r_beat] <= mem_data;
            r_beat        <= r_beat + 2'd1;
          end
        end
        READ:    cpu_data <= cache_out;
        default: ;
      endcase
    end
  end

  always_comb begin
    w_state_next = r_state;
    cpu_ready    = 1'b0;
    cache_read   = 1'b0;
    cache_write  = 1'b0;
    mem_read     = 1'b0;
    case (r_state)
      IDLE:    if (cpu_read) w_state_next = COMPARE;
      COMPARE: w_state_next = cache_hit ? READ : FETCH;
      FETCH: begin
        mem_read = 1'b1;
        if (mem_valid && (r_beat == 2'd3)) w_state_next = FILL;
      end
      // The hit flag is not rechecked after a fill: the line is known good.
      FILL: begin
        cache_write  = 1'b1;
        w_state_next = READ;
      end
      READ: begin
        cache_read   = 1'b1;
        w_state_next = DONE;
      end
      DONE: begin
        cpu_ready    = 1'b1;
        w_state_next = IDLE;
      end
      default: w_state_next = IDLE;
    endcase
  end

  assign cache_address = r_addr;
  assign mem_address   = {r_addr[ADDR_WIDTH-1:2], 2'b00};
  assign cache_data1   = r_buf[0];
  assign cache_data2   = r_buf[1];
  assign cache_data3   = r_buf[2];
  assign cache_data4   = r_buf[3];

`ifdef CACHE_STATS_EN
  always_ff @(posedge clk) begin
    if (rst) begin
      hit_count  <= 16'd0;
      miss_count <= 16'd0;
    end else if (r_state == COMPARE) begin
      if (cache_hit) hit_count  <= hit_count + 16'd1;
      else           miss_count <= miss_count + 16'd1;
    end
  end
`endif

endmodule

`default_nettype wire

// File: tb/tb_cache_controller.sv
//==============================================================================
// Module      : tb_cache_controller
// Description : Directed bench for cache_controller with a behavioural
//               direct-mapped cache and a beat-wise main-memory responder.
// Revision    : 1.0 - initial release
//==============================================================================
`default_nettype none

module tb_cache_controller;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        cpu_read = 1'b0;
  logic [14:0] cpu_address = '0;
  logic        cpu_ready;
  logic [31:0] cpu_data;
  logic        cache_read, cache_write;
  logic [14:0] cache_address;
  logic [31:0] cache_data1, cache_data2, cache_data3, cache_data4;
  logic        cache_hit = 1'b0;
  logic [31:0] cache_out = '0;
  logic        mem_read;
  logic [14:0] mem_address;
  logic        mem_valid = 1'b0;
  logic [31:0] mem_data = '0;
`ifdef CACHE_STATS_EN
  logic [15:0] hit_count, miss_count;
`endif

  int vectors = 0;
  int miscompares = 0;

  cache_controller dut (
    .clk(clk), .rst(rst),
    .cpu_read(cpu_read), .cpu_address(cpu_address),
    .cpu_ready(cpu_ready), .cpu_data(cpu_data),
    .cache_read(cache_read), .cache_write(cache_write),
    .cache_address(cache_address),
    .cache_data1(cache_data1), .cache_data2(cache_data2),
    .cache_data3(cache_data3), .cache_data4(cache_data4),
    .cache_hit(cache_hit), .cache_out(cache_out),
    .mem_read(mem_read), .mem_address(mem_address),
    .mem_valid(mem_valid), .mem_data(mem_data)
`ifdef CACHE_STATS_EN
    , .hit_count(hit_count), .miss_count(miss_count)
`endif
  );

  always #5 clk = ~clk;

  // Main memory contents: two named blocks plus an address-derived pattern.
  function automatic logic [31:0] mem_word(input logic [14:0] a);
    if (a[14:2] == 13'h048D) return 32'hA0 + {30'b0, a[1:0]};
    if (a[14:2] == 13'h088D) return 32'hB0 + {30'b0, a[1:0]};
    return 32'hC0DE_0000 | {17'b0, a};
  endfunction

  // Behavioural cache_memory: hit recomputed only when the address changes.
  logic        c_valid [0:1023];
  logic [2:0]  c_tag   [0:1023];
  logic [31:0] c_data  [0:1023][0:3];
  initial for (int i = 0; i < 1024; i++) c_valid[i] = 1'b0;

  always @(cache_address)
    cache_hit = c_valid[cache_address[11:2]] && (c_tag[cache_address[11:2]] == cache_address[14:12]);

  always @(posedge clk) begin
    if (cache_write) begin
      c_valid[cache_address[11:2]]   <= 1'b1;
      c_tag[cache_address[11:2]]     <= cache_address[14:12];
      c_data[cache_address[11:2]][0] <= cache_data1;
      c_data[cache_address[11:2]][1] <= cache_data2;
      c_data[cache_address[11:2]][2] <= cache_data3;
      c_data[cache_address[11:2]][3] <= cache_data4;
    end
  end

  always @(posedge cache_read) cache_out <= c_data[cache_address[11:2]][cache_address[1:0]];

  // Memory responder: one beat per (gap+1) cycles while mem_read is held.
  int gap = 0;
  int gap_cnt = 0;
  int beat_idx = 0;
  int beats_sent = 0;
  always @(negedge clk) begin
    mem_valid = 1'b0;
    if (mem_read && !rst) begin
      if (gap_cnt > 0) gap_cnt--;
      else if (beat_idx < 4) begin
        mem_valid = 1'b1;
        mem_data  = mem_word({mem_address[14:2], 2'(beat_idx)});
        beat_idx++;
        beats_sent++;
        gap_cnt = gap;
      end
    end else begin
      beat_idx = 0;
      gap_cnt  = 0;
    end
  end

  // Passive monitor of strobes between requests.
  int           wr_cycles = 0;
  int           mem_rd_cycles = 0;
  logic [127:0] fill_seen = '0;
  logic [14:0]  mem_addr_seen = '0;
  always @(negedge clk) begin
    if (cache_write) begin
      wr_cycles++;
      fill_seen = {cache_data1, cache_data2, cache_data3, cache_data4};
    end
    if (mem_read) begin
      mem_rd_cycles++;
      mem_addr_seen = mem_address;
    end
  end

  // Issues one read; lat counts edges from the sampling edge to the edge that sees cpu_ready.
  task automatic do_read(input logic [14:0] addr, output int lat, output logic [31:0] data);
    int cyc;
    lat  = 0;
    data = 'x;
    @(negedge clk);
    wr_cycles = 0; mem_rd_cycles = 0; beats_sent = 0;
    cpu_read = 1'b1; cpu_address = addr;
    @(posedge clk);
    cyc = 0;
    @(negedge clk);
    cpu_read = 1'b0;
    while (cyc < 200) begin
      if (cpu_ready) begin
        lat  = cyc + 1;
        data = cpu_data;
        break;
      end
      @(posedge clk);
      cyc++;
      @(negedge clk);
    end
  endtask

  task automatic test_reset();
    rst = 1'b1;
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    vectors++; if (cpu_ready !== 1'b0 || cpu_data !== 32'h0) begin miscompares++; $display("FAIL reset_cpu: ready=%b data=%h want 0/0", cpu_ready, cpu_data); end
    vectors++; if ({cache_read, cache_write, mem_read} !== 3'b000) begin miscompares++; $display("FAIL reset_strobes: rd/wr/mem=%b want 000", {cache_read, cache_write, mem_read}); end
    vectors++; if (cache_address !== 15'h0 || mem_address !== 15'h0) begin miscompares++; $display("FAIL reset_addr: cache=%h mem=%h want 0", cache_address, mem_address); end
    vectors++; if ({cache_data1, cache_data2, cache_data3, cache_data4} !== 128'h0) begin miscompares++; $display("FAIL reset_fill: got %h want 0", {cache_data1, cache_data2, cache_data3, cache_data4}); end
`ifdef CACHE_STATS_EN
    vectors++; if (hit_count !== 16'd0 || miss_count !== 16'd0) begin miscompares++; $display("FAIL reset_stats: hit=%0d miss=%0d want 0", hit_count, miss_count); end
`endif
  endtask

  task automatic test_cold_miss();
    int lat; logic [31:0] d;
    gap = 0;
    do_read(15'h1235, lat, d);
    vectors++; if (lat !== 8) begin miscompares++; $display("FAIL cold_latency: got %0d want 8", lat); end
    vectors++; if (d !== 32'hA1) begin miscompares++; $display("FAIL cold_data: got %h want a1", d); end
    vectors++; if (mem_addr_seen !== 15'h1234) begin miscompares++; $display("FAIL cold_mem_addr: got %h want 1234", mem_addr_seen); end
    vectors++; if (wr_cycles !== 1) begin miscompares++; $display("FAIL cold_write_cycles: got %0d want 1", wr_cycles); end
    vectors++; if (mem_rd_cycles !== 4) begin miscompares++; $display("FAIL cold_mem_read_cycles: got %0d want 4", mem_rd_cycles); end
    vectors++; if (fill_seen !== 128'h000000A0_000000A1_000000A2_000000A3) begin miscompares++; $display("FAIL cold_fill: got %h", fill_seen); end
  endtask

  task automatic test_same_block_hit();
    int lat; logic [31:0] d;
    do_read(15'h1237, lat, d);
    vectors++; if (lat !== 3) begin miscompares++; $display("FAIL hit_latency: got %0d want 3", lat); end
    vectors++; if (d !== 32'hA3) begin miscompares++; $display("FAIL hit_data: got %h want a3", d); end
    vectors++; if (mem_rd_cycles !== 0 || wr_cycles !== 0) begin miscompares++; $display("FAIL hit_no_fetch: mem_read cycles=%0d writes=%0d want 0/0", mem_rd_cycles, wr_cycles); end
  endtask

  task automatic test_conflict_miss();
    int lat; logic [31:0] d;
    do_read(15'h2234, lat, d);
    vectors++; if (lat !== 8) begin miscompares++; $display("FAIL conflict_latency: got %0d want 8", lat); end
    vectors++; if (d !== 32'hB0) begin miscompares++; $display("FAIL conflict_data: got %h want b0", d); end
    vectors++; if (mem_addr_seen !== 15'h2234 || wr_cycles !== 1) begin miscompares++; $display("FAIL conflict_fetch: mem_addr=%h writes=%0d want 2234/1", mem_addr_seen, wr_cycles); end
  endtask

  task automatic test_counters();
`ifdef CACHE_STATS_EN
    vectors++; if (hit_count !== 16'd1 || miss_count !== 16'd2) begin miscompares++; $display("FAIL stats_count: hit=%0d miss=%0d want 1/2", hit_count, miss_count); end
`endif
  endtask

  task automatic test_conflict_reread();
    int lat; logic [31:0] d;
    do_read(15'h1234, lat, d);
    vectors++; if (lat !== 8 || mem_rd_cycles !== 4) begin miscompares++; $display("FAIL reread_miss: latency=%0d mem_read cycles=%0d want 8/4", lat, mem_rd_cycles); end
    vectors++; if (d !== 32'hA0) begin miscompares++; $display("FAIL reread_data: got %h want a0", d); end
  endtask

  task automatic test_gapped_beats();
    int lat; logic [31:0] d;
    gap = 2;
    do_read(15'h0567, lat, d);
    gap = 0;
    vectors++; if (lat !== 14) begin miscompares++; $display("FAIL gap_latency: got %0d want 14", lat); end
    vectors++; if (d !== 32'hC0DE0567) begin miscompares++; $display("FAIL gap_data: got %h want c0de0567", d); end
    vectors++; if (fill_seen !== 128'hC0DE0564_C0DE0565_C0DE0566_C0DE0567) begin miscompares++; $display("FAIL gap_fill: got %h", fill_seen); end
  endtask

  task automatic test_reset_mid_fetch();
    int lat; int n; logic [31:0] d;
    @(negedge clk);
    wr_cycles = 0; beats_sent = 0;
    cpu_read = 1'b1; cpu_address = 15'h0ABC;
    @(negedge clk);
    cpu_read = 1'b0;
    n = 0;
    while (beats_sent < 2 && n < 50) begin
      @(posedge clk);
      n++;
    end
    vectors++; if (beats_sent < 2) begin miscompares++; $display("FAIL rstmid_beats: got %0d beats want 2 before timeout", beats_sent); end
    #1 rst = 1'b1;
    @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    vectors++; if (mem_read !== 1'b0 || cache_address !== 15'h0) begin miscompares++; $display("FAIL rstmid_idle: mem_read=%b addr=%h want 0/0", mem_read, cache_address); end
    repeat (6) @(negedge clk);
    vectors++; if (wr_cycles !== 0 || mem_read !== 1'b0) begin miscompares++; $display("FAIL rstmid_no_write: writes=%0d mem_read=%b want 0/0", wr_cycles, mem_read); end
`ifdef CACHE_STATS_EN
    vectors++; if (hit_count !== 16'd0 || miss_count !== 16'd0) begin miscompares++; $display("FAIL rstmid_stats: hit=%0d miss=%0d want 0", hit_count, miss_count); end
`endif
    do_read(15'h0ABC, lat, d);
    vectors++; if (beats_sent !== 4 || lat !== 8) begin miscompares++; $display("FAIL rstmid_refetch: beats=%0d latency=%0d want 4/8", beats_sent, lat); end
    vectors++; if (d !== 32'hC0DE0ABC) begin miscompares++; $display("FAIL rstmid_data: got %h want c0de0abc", d); end
  endtask

  // Same address immediately after a fill: stale hit flag forces a refetch.
  task automatic test_back_to_back();
    int lat; logic [31:0] d;
    do_read(15'h0ABC, lat, d);
    vectors++; if (lat !== 8 || mem_rd_cycles !== 4 || wr_cycles !== 1) begin miscompares++; $display("FAIL b2b_stale: latency=%0d mem_read cycles=%0d writes=%0d want 8/4/1", lat, mem_rd_cycles, wr_cycles); end
    vectors++; if (d !== 32'hC0DE0ABC) begin miscompares++; $display("FAIL b2b_data: got %h want c0de0abc", d); end
    do_read(15'h0ABD, lat, d);
    vectors++; if (lat !== 3 || d !== 32'hC0DE0ABD) begin miscompares++; $display("FAIL b2b_hit: latency=%0d data=%h want 3/c0de0abd", lat, d); end
  endtask

  initial begin
    test_reset();
    test_cold_miss();
    test_same_block_hit();
    test_conflict_miss();
    test_counters();
    test_conflict_reread();
    test_gapped_beats();
    test_reset_mid_fetch();
    test_back_to_back();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

`default_nettype wire
